// File: rtl/compare_arbiter.sv
// rtl/compare_arbiter.sv - round-robin arbiter sequencing requesters onto the port-mapped compare unit
// Optional write-skip operand cache enabled by defining COMPARE_ARB_SKIP_EN
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef PORT_COMPARE_DATA
`define PORT_COMPARE_DATA 8'h01
`endif
`ifndef PORT_COMPARED_DATA
`define PORT_COMPARED_DATA 8'h02
`endif
`ifndef PORT_COMPARE_RESULT
`define PORT_COMPARE_RESULT 8'h03
`endif

module compare_arbiter #(
   parameter int NUM_REQ = 4,
   parameter logic [`DATA_WIDTH-1:0] IDLE_PORT = `DATA_WIDTH'hFF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             i_req,
   input  logic [NUM_REQ*`DATA_WIDTH-1:0] i_a,
   input  logic [NUM_REQ*`DATA_WIDTH-1:0] i_b,
   output logic [NUM_REQ-1:0]             o_gnt,
   output logic [NUM_REQ-1:0]             o_done,
   output logic [1:0]                     o_result,
   output logic                           o_busy,
   output logic [`DATA_WIDTH-1:0]         o_cmp_data,
   output logic [`DATA_WIDTH-1:0]         o_cmp_port,
   input  logic [`DATA_WIDTH-1:0]         i_cmp_result
);
   localparam int DW = `DATA_WIDTH;
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD, CAP, DONE} state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] cand;
   logic          found;
   logic [DW-1:0] a_lat;
   logic [DW-1:0] b_lat;
   logic [DW-1:0] a_new;
   logic [DW-1:0] b_new;
   logic          skip_a_new;
   logic          skip_b_new;
   logic          skip_b_lat;
   logic          unused_result_bits;

   assign unused_result_bits = ^i_cmp_result[DW-1:2];

   // First requester above the pointer, wrapping, so the last winner ranks lowest.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = PW'((int'(ptr) + i) % NUM_REQ);
         if (!found && i_req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign a_new = i_a[int'(win)*DW +: DW];
   assign b_new = i_b[int'(win)*DW +: DW];

`ifdef COMPARE_ARB_SKIP_EN
   logic [DW-1:0] cache_a;
   logic [DW-1:0] cache_b;
   logic          cache_a_valid;
   logic          cache_b_valid;

   assign skip_a_new = cache_a_valid && (cache_a == a_new);
   assign skip_b_new = cache_b_valid && (cache_b == b_new);
   assign skip_b_lat = cache_b_valid && (cache_b == b_lat);
`else
   assign skip_a_new = 1'b0;
   assign skip_b_new = 1'b0;
   assign skip_b_lat = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= PW'(NUM_REQ - 1);
         o_gnt      <= '0;
         o_done     <= '0;
         o_result   <= '0;
         o_busy     <= 1'b0;
         o_cmp_port <= IDLE_PORT;
         o_cmp_data <= '0;
         a_lat      <= '0;
         b_lat      <= '0;
`ifdef COMPARE_ARB_SKIP_EN
         cache_a       <= '0;
         cache_b       <= '0;
         cache_a_valid <= 1'b0;
         cache_b_valid <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  a_lat  <= a_new;
                  b_lat  <= b_new;
                  o_gnt  <= ONE << win;
                  ptr    <= win;
                  o_busy <= 1'b1;
                  if (!skip_a_new) begin
                     state      <= WR_A;
                     o_cmp_port <= `PORT_COMPARE_DATA;
                     o_cmp_data <= a_new;
`ifdef COMPARE_ARB_SKIP_EN
                     cache_a       <= a_new;
                     cache_a_valid <= 1'b1;
`endif
                  end else if (!skip_b_new) begin
                     state      <= WR_B;
                     o_cmp_port <= `PORT_COMPARED_DATA;
                     o_cmp_data <= b_new;
`ifdef COMPARE_ARB_SKIP_EN
                     cache_b       <= b_new;
                     cache_b_valid <= 1'b1;
`endif
                  end else begin
                     state      <= RD;
                     o_cmp_port <= `PORT_COMPARE_RESULT;
                     o_cmp_data <= '0;
                  end
               end
            end
            WR_A: begin
               if (!skip_b_lat) begin
                  state      <= WR_B;
                  o_cmp_port <= `PORT_COMPARED_DATA;
                  o_cmp_data <= b_lat;
`ifdef COMPARE_ARB_SKIP_EN
                  cache_b       <= b_lat;
                  cache_b_valid <= 1'b1;
`endif
               end else begin
                  state      <= RD;
                  o_cmp_port <= `PORT_COMPARE_RESULT;
                  o_cmp_data <= '0;
               end
            end
            WR_B: begin
               state      <= RD;
               o_cmp_port <= `PORT_COMPARE_RESULT;
               o_cmp_data <= '0;
            end
            RD: begin
               state      <= CAP;
               o_cmp_port <= IDLE_PORT;
               o_cmp_data <= '0;
            end
            CAP: begin
               state    <= DONE;
               o_result <= i_cmp_result[1:0];
               o_done   <= o_gnt;
            end
            DONE: begin
               state  <= IDLE;
               o_done <= '0;
               o_gnt  <= '0;
               o_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_compare_arbiter.sv
// tb/tb_compare_arbiter.sv - randomized self-checking bench for compare_arbiter
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef PORT_COMPARE_DATA
`define PORT_COMPARE_DATA 8'h01
`endif
`ifndef PORT_COMPARED_DATA
`define PORT_COMPARED_DATA 8'h02
`endif
`ifndef PORT_COMPARE_RESULT
`define PORT_COMPARE_RESULT 8'h03
`endif

module tb_compare_arbiter;
   localparam int N  = 4;
   localparam int DW = `DATA_WIDTH;
   localparam logic [DW-1:0] P_A = `PORT_COMPARE_DATA;
   localparam logic [DW-1:0] P_B = `PORT_COMPARED_DATA;
   localparam logic [DW-1:0] P_R = `PORT_COMPARE_RESULT;
   localparam logic [DW-1:0] P_I = 8'hFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req = '0;
   logic [N*DW-1:0] a_bus = '0;
   logic [N*DW-1:0] b_bus = '0;
   logic [N-1:0]  gnt;
   logic [N-1:0]  done;
   logic [1:0]    result;
   logic          busy;
   logic [DW-1:0] cmp_data;
   logic [DW-1:0] cmp_port;
   logic [DW-1:0] cmp_result;

   int tests = 0;
   int fails = 0;

   compare_arbiter #(.NUM_REQ(N), .IDLE_PORT(P_I)) dut (
      .clk(clk), .rst(rst), .i_req(req), .i_a(a_bus), .i_b(b_bus),
      .o_gnt(gnt), .o_done(done), .o_result(result), .o_busy(busy),
      .o_cmp_data(cmp_data), .o_cmp_port(cmp_port), .i_cmp_result(cmp_result)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] ref_code(input logic [DW-1:0] a, input logic [DW-1:0] b);
      if (a > b) return 2'b01;
      if (a < b) return 2'b10;
      return 2'b11;
   endfunction

   // Compare unit stand-in: write ports latch operands, result port is read one cycle later.
   logic [DW-1:0] cu_a, cu_b;
   logic          force_en = 1'b0;
   logic [1:0]    force_code = 2'b00;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cu_a <= '0; cu_b <= '0; cmp_result <= '0;
      end else begin
         if (cmp_port == P_A) cu_a <= cmp_data;
         if (cmp_port == P_B) cu_b <= cmp_data;
         if (cmp_port == P_R)
            cmp_result <= {{(DW-2){1'b0}}, (force_en ? force_code : ref_code(cu_a, cu_b))};
      end
   end

   logic [2*DW-1:0] wq[$];
   int nreads = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (cmp_port == P_A || cmp_port == P_B) wq.push_back({cmp_port, cmp_data});
         if (cmp_port == P_R) nreads++;
      end
   end

   // Reference model: round-robin pointer and (optionally) the last-written operand cache.
   int m_ptr = N - 1;
`ifdef COMPARE_ARB_SKIP_EN
   bit m_cav, m_cbv;
   logic [DW-1:0] m_ca, m_cb;
`endif

   function automatic void model_reset();
      m_ptr = N - 1;
`ifdef COMPARE_ARB_SKIP_EN
      m_cav = 0; m_cbv = 0;
`endif
   endfunction

   function automatic int model_lat(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef COMPARE_ARB_SKIP_EN
      int w = 0;
      if (!(m_cav && m_ca == a)) begin w++; m_ca = a; m_cav = 1; end
      if (!(m_cbv && m_cb == b)) begin w++; m_cb = b; m_cbv = 1; end
      return 3 + w;
`else
      return 5 + 0 * int'(a ^ b);
`endif
   endfunction

   function automatic int model_pick(input logic [N-1:0] p);
      for (int i = 1; i <= N; i++)
         if (p[(m_ptr + i) % N]) return (m_ptr + i) % N;
      return -1;
   endfunction

   task automatic single(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input bit drop, output int lat, output logic [1:0] res,
                         output logic [N-1:0] dv, output bit steady);
      a_bus[k*DW +: DW] = a;
      b_bus[k*DW +: DW] = b;
      req[k] = 1'b1;
      wq.delete();
      nreads = 0;
      lat = 0; res = 2'b00; dv = '0; steady = 1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (gnt !== (N'(1) << k)) steady = 0;
         if (drop && n == 1) begin
            req[k] = 1'b0;
            a_bus[k*DW +: DW] = ~a;
         end
         if (done !== '0) begin
            lat = n; res = result; dv = done;
            req[k] = 1'b0;
            break;
         end
      end
      req[k] = 1'b0;
      m_ptr = k;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++; if (gnt !== '0) begin fails++; $display("FAIL reset_gnt got %b exp 0", gnt); end
      tests++; if (done !== '0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
      tests++; if (result !== 2'b00) begin fails++; $display("FAIL reset_result got %b exp 00", result); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      tests++; if (cmp_port !== P_I) begin fails++; $display("FAIL reset_port got %h exp %h", cmp_port, P_I); end
      tests++; if (cmp_data !== '0) begin fails++; $display("FAIL reset_data got %h exp 0", cmp_data); end
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, el; logic [1:0] res; logic [N-1:0] dv; bit st;
      el = model_lat(8'h20, 8'h10);
      single(0, 8'h20, 8'h10, 0, lat, res, dv, st);
      tests++; if (lat != el) begin fails++; $display("FAIL basic_latency got %0d exp %0d", lat, el); end
      tests++; if (res !== 2'b01) begin fails++; $display("FAIL basic_result got %b exp 01", res); end
      tests++; if (dv !== 4'b0001) begin fails++; $display("FAIL basic_done got %b exp 0001", dv); end
      tests++; if (!st) begin fails++; $display("FAIL basic_gnt_steady got 0 exp 1"); end
      tests++;
      if (wq.size() != 2) begin
         fails++; $display("FAIL basic_writes got %0d writes exp 2", wq.size());
      end else if (wq[0] !== {P_A, 8'h20} || wq[1] !== {P_B, 8'h10}) begin
         fails++; $display("FAIL basic_write_seq got %h,%h exp %h,%h", wq[0], wq[1], {P_A, 8'h20}, {P_B, 8'h10});
      end
      tests++; if (nreads != 1) begin fails++; $display("FAIL basic_reads got %0d exp 1", nreads); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after got %b exp 0", busy); end
   endtask

   task automatic test_codes();
      int lat, el, k; logic [1:0] res; logic [N-1:0] dv; bit st; logic [DW-1:0] a, b;
      el = model_lat(8'h05, 8'h09);
      single(2, 8'h05, 8'h09, 0, lat, res, dv, st);
      tests++; if (res !== 2'b10) begin fails++; $display("FAIL codes_lt got %b exp 10", res); end
      tests++; if (!st || dv !== 4'b0100) begin fails++; $display("FAIL codes_lt_gnt done %b exp 0100 steady %0d", dv, st); end
      el = model_lat(8'h33, 8'h33);
      single(2, 8'h33, 8'h33, 0, lat, res, dv, st);
      tests++; if (res !== 2'b11) begin fails++; $display("FAIL codes_eq got %b exp 11", res); end
      tests++; if (!st || dv !== 4'b0100) begin fails++; $display("FAIL codes_eq_gnt done %b exp 0100 steady %0d", dv, st); end
      force_en = 1'b1; force_code = 2'b00;
      a = DW'($urandom); b = DW'($urandom);
      el = model_lat(a, b);
      single(1, a, b, 0, lat, res, dv, st);
      force_en = 1'b0;
      tests++; if (res !== 2'b00 || lat != el) begin fails++; $display("FAIL codes_zero got %b lat %0d exp 00 lat %0d", res, lat, el); end
      for (int i = 0; i < 10; i++) begin
         k = $urandom_range(0, N - 1);
         a = DW'($urandom);
         b = ($urandom_range(0, 3) == 0) ? a : DW'($urandom);
         el = model_lat(a, b);
         single(k, a, b, 0, lat, res, dv, st);
         tests++;
         if (res !== ref_code(a, b) || lat != el || dv !== (N'(1) << k) || !st) begin
            fails++;
            $display("FAIL codes_rand k=%0d a=%h b=%h got res %b lat %0d done %b exp res %b lat %0d",
                     k, a, b, res, lat, dv, ref_code(a, b), el);
         end
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] pend; int n, rounds, exp_w, el; bit raise_now, reraised;
      logic [DW-1:0] av [N]; logic [DW-1:0] bv [N];
      rst = 1'b1; @(negedge clk); rst = 1'b0; model_reset();
      for (int i = 0; i < N; i++) begin
         av[i] = DW'($urandom); bv[i] = DW'($urandom);
         a_bus[i*DW +: DW] = av[i]; b_bus[i*DW +: DW] = bv[i];
      end
      pend = 4'b1011; req = pend;
      n = 0; rounds = 0; raise_now = 0; reraised = 0;
      while (rounds < 4 && n < 40) begin
         @(negedge clk); n++;
         if (raise_now) begin req[0] = 1'b1; pend[0] = 1'b1; raise_now = 0; end
         if (done !== '0) begin
            exp_w = model_pick(pend);
            el = model_lat(av[exp_w], bv[exp_w]) + ((rounds > 0) ? 1 : 0);
            tests++; if (done !== (N'(1) << exp_w) || gnt !== done) begin
               fails++; $display("FAIL fair_order round %0d got done %b gnt %b exp %b", rounds, done, gnt, N'(1) << exp_w);
            end
            tests++; if (n != el) begin fails++; $display("FAIL fair_period round %0d got %0d exp %0d", rounds, n, el); end
            tests++; if (result !== ref_code(av[exp_w], bv[exp_w])) begin
               fails++; $display("FAIL fair_result round %0d got %b exp %b", rounds, result, ref_code(av[exp_w], bv[exp_w]));
            end
            m_ptr = exp_w; pend[exp_w] = 1'b0; req[exp_w] = 1'b0;
            if (exp_w == 0 && !reraised) begin raise_now = 1; reraised = 1; end
            n = 0; rounds++;
         end
      end
      tests++; if (rounds != 4) begin fails++; $display("FAIL fair_timeout got %0d rounds exp 4", rounds); end
      req = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat, el, seen; logic [1:0] res; logic [N-1:0] dv; bit st; logic [DW-1:0] a, b;
      a_bus[1*DW +: DW] = 8'h44; b_bus[1*DW +: DW] = 8'h22;
      req[1] = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      tests++; if (gnt !== '0 || done !== '0 || busy !== 1'b0) begin
         fails++; $display("FAIL midrst_ctrl got gnt %b done %b busy %b exp 0 0 0", gnt, done, busy);
      end
      tests++; if (cmp_port !== P_I || cmp_data !== '0 || result !== 2'b00) begin
         fails++; $display("FAIL midrst_bus got port %h data %h res %b exp %h 0 0", cmp_port, cmp_data, result, P_I);
      end
      req[1] = 1'b0;
      @(negedge clk); rst = 1'b0; model_reset();
      seen = 0;
      repeat (8) begin @(negedge clk); if (done !== '0) seen++; end
      tests++; if (seen != 0) begin fails++; $display("FAIL midrst_no_done got %0d pulses exp 0", seen); end
      a = DW'($urandom); b = DW'($urandom);
      el = model_lat(a, b);
      single(1, a, b, 0, lat, res, dv, st);
      tests++; if (lat != el || res !== ref_code(a, b) || dv !== 4'b0010) begin
         fails++; $display("FAIL midrst_rereq got lat %0d res %b done %b exp %0d %b 0010", lat, res, dv, el, ref_code(a, b));
      end
   endtask

   task automatic test_drop();
      int lat, el; logic [1:0] res; logic [N-1:0] dv; bit st;
      el = model_lat(8'h30, 8'h40);
      single(1, 8'h30, 8'h40, 1, lat, res, dv, st);
      tests++; if (lat != el || dv !== 4'b0010) begin fails++; $display("FAIL drop_done got lat %0d done %b exp %0d 0010", lat, dv, el); end
      tests++; if (res !== 2'b10) begin fails++; $display("FAIL drop_result got %b exp 10", res); end
      tests++; if (wq.size() < 1 || wq[0] !== {P_A, 8'h30}) begin
         fails++; $display("FAIL drop_operand got %0d writes first %h exp %h", wq.size(), (wq.size() > 0) ? wq[0] : '0, {P_A, 8'h30});
      end
   endtask

`ifdef COMPARE_ARB_SKIP_EN
   task automatic test_skip();
      int lat, el; logic [1:0] res; logic [N-1:0] dv; bit st;
      el = model_lat(8'h20, 8'h10);
      single(0, 8'h20, 8'h10, 0, lat, res, dv, st);
      tests++; if (lat != el || res !== 2'b01) begin fails++; $display("FAIL skip_first got lat %0d res %b exp %0d 01", lat, res, el); end
      el = model_lat(8'h20, 8'h10);
      single(0, 8'h20, 8'h10, 0, lat, res, dv, st);
      tests++; if (lat != 3 || wq.size() != 0 || res !== 2'b01) begin
         fails++; $display("FAIL skip_both got lat %0d writes %0d res %b exp 3 0 01", lat, wq.size(), res);
      end
      el = model_lat(8'h20, 8'h40);
      single(0, 8'h20, 8'h40, 0, lat, res, dv, st);
      tests++; if (lat != 4 || res !== 2'b10) begin fails++; $display("FAIL skip_b_only got lat %0d res %b exp 4 10", lat, res); end
      tests++; if (wq.size() != 1 || wq[0] !== {P_B, 8'h40}) begin
         fails++; $display("FAIL skip_b_write got %0d writes exp 1 of %h", wq.size(), {P_B, 8'h40});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_codes();
      test_fairness();
      test_reset_mid();
      test_drop();
`ifdef COMPARE_ARB_SKIP_EN
      test_skip();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0d tests", tests);
      $fatal(1);
   end
endmodule

// File: doc/compare_arbiter.md
Name: compare_arbiter

Overview:
Shares the single port-mapped compare unit between NUM_REQ requesters. Arbitration is round-robin. For the granted requester, the block sequences the port writes: operand 1, then operand 2, then the result-port read. It captures the 2-bit result code and returns it with a one-cycle done pulse. It sits between the requesters and the compare unit's i_data/i_port/o_data bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDLE_PORT, `DATA_WIDTH'hFF, port code driven when no access is in progress; must differ from `PORT_COMPARE_DATA, `PORT_COMPARED_DATA and `PORT_COMPARE_RESULT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
i_req  in  NUM_REQ  per-requester request level
i_a  in  NUM_REQ*`DATA_WIDTH  operand 1 per requester; requester k occupies [k*DW +: DW]
i_b  in  NUM_REQ*`DATA_WIDTH  operand 2 per requester, same packing
o_gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
o_done  out  NUM_REQ  one-hot, one-cycle completion pulse
o_result  out  2  compare code: 01 means a>b, 10 means a<b, 11 means a==b; valid while o_done is nonzero
o_busy  out  1  high when state is not IDLE
o_cmp_data  out  `DATA_WIDTH  drives compare unit i_data
o_cmp_port  out  `DATA_WIDTH  drives compare unit i_port
i_cmp_result  in  `DATA_WIDTH  compare unit o_data

Behaviour:
- Reset values:
  - state IDLE; o_gnt=0; o_done=0; o_result=0; o_busy=0
  - o_cmp_port=IDLE_PORT; o_cmp_data=0
  - round-robin pointer points at requester NUM_REQ-1, so requester 0 has first priority
- All outputs are registered.
- FSM states: IDLE, WR_A, WR_B, RD, CAP, DONE.
- IDLE:
  - If any i_req bit is set, choose the first set bit searching upward from pointer+1, with wrap-around.
  - Latch that requester's i_a and i_b into internal registers.
  - Set o_gnt, update the pointer to the winner, and go to WR_A.
  - Operands are sampled only at grant; the requester may change them afterwards.
- WR_A: o_cmp_port=`PORT_COMPARE_DATA, o_cmp_data=A latch. Go to WR_B.
- WR_B: o_cmp_port=`PORT_COMPARED_DATA, o_cmp_data=B latch. Go to RD.
- RD: o_cmp_port=`PORT_COMPARE_RESULT, o_cmp_data=0. Go to CAP.
- CAP:
  - o_cmp_port=IDLE_PORT.
  - Register i_cmp_result[1:0] into o_result.
  - Set o_done to the grant vector and go to DONE.
- DONE: o_done and o_gnt high for exactly this cycle, then go to IDLE with both cleared.
- Requester handshake: the requester must deassert i_req in the DONE cycle. A request still high in the next IDLE cycle is a new transaction.
- Latency: request seen in IDLE at cycle t leads to o_done at t+5. Back-to-back period is 6 cycles.
- Simultaneous requests: exactly one is granted. Others wait; their i_req must stay high.
- Fairness: a requester re-requesting immediately after DONE has lowest priority next round.
- Requests arriving mid-transaction are ignored until IDLE.
- An i_req drop after grant has no effect; the transaction completes and done still pulses.
- Reset mid-transaction:
  - The transaction is aborted; no done is issued and the requester must re-request.
  - The compare unit's reset must be asserted in the same window.
- An i_cmp_result code of 00 is passed through unchanged.

Optional Feature:
COMPARE_ARB_SKIP_EN
- Defined:
  - The block keeps last-written A and B copies with valid flags; the flags are cleared on reset.
  - WR_A is skipped if A latch equals the valid cached A; WR_B is skipped likewise for B.
  - The FSM goes straight to the next needed state.
  - Minimum latency is t+3 when both writes are skipped.
- Undefined: no cache; both writes always occur; fixed 5-cycle latency.

Test Plan:
1. Reset, then requester 0 with a=8'h20, b=8'h10 -> port sequence PORT_COMPARE_DATA/20, PORT_COMPARED_DATA/10, PORT_COMPARE_RESULT; o_done=0001 at t+5 with o_result=01.
2. Requester 2 with a=8'h05, b=8'h09, then a=b=8'h33 -> o_result=10, then 11; o_gnt=0100 throughout both.
3. Requesters 0, 1 and 3 raised together and held -> grants in order 0, 1, 3; each done 6 cycles apart; 0 re-requesting is served after 3.
4. Assert rst during WR_B -> all outputs return to reset values immediately; no done pulse; a re-request completes normally.
5. Requester 1 drops i_req in WR_A and changes i_a -> transaction completes using the operands latched at grant.
6. With COMPARE_ARB_SKIP_EN, the same a=8'h20, b=8'h10 issued twice -> second transaction has no write cycles, done at t+3, o_result=01; changing only b to 8'h40 -> only the WR_B write occurs, o_result=10.
